// File: rtl/muldiv_unit_if.sv
// Handshake and result bundle between the E-stage issue logic and the iterative multiply/divide unit.
interface muldiv_unit_if;
    logic        startE;
    logic [1:0]  opE;
    logic [31:0] srcaE;
    logic [31:0] srcbE;
    logic        hiloreadE;
    logic        busy;
    logic        stallMD;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output startE, opE, srcaE, srcbE, hiloreadE,
        input  busy, stallMD, done, hi, lo
    );

    modport slave (
        input  startE, opE, srcaE, srcbE, hiloreadE,
        output busy, stallMD, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit, 32 cycles per operation, HI/LO result registers.
// Divide support is compiled only when MULDIV_DIVIDE_EN is defined; otherwise DIV/DIVU are no-ops.
module muldiv_unit (
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave md
);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e      state_q, state_d;
    logic [5:0]  count_q, count_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        done_q, done_d;
    logic [63:0] work_q, work_d;
    logic [31:0] opnd_q, opnd_d;
    logic        sa_q, sa_d, sb_q, sb_d;

    logic        busy;
    logic        accept;
    logic        start_div;
    logic        sign_a, sign_b;
    logic [31:0] abs_a, abs_b;
    logic [32:0] msum;
    logic [63:0] mul_step;
    logic [63:0] step;
    logic [31:0] res_hi, res_lo;

    // Two's-complement negate when neg is set; used both for magnitudes and final sign correction.
    function automatic logic [31:0] fix32(input logic neg, input logic [31:0] v);
        return neg ? (~v + 32'd1) : v;
    endfunction

    function automatic logic [63:0] fix64(input logic neg, input logic [63:0] v);
        return neg ? (~v + 64'd1) : v;
    endfunction

    assign busy   = (state_q == BUSY);
    assign sign_a = md.opE[0] & md.srcaE[31];
    assign sign_b = md.opE[0] & md.srcbE[31];
    assign abs_a  = fix32(sign_a, md.srcaE);
    assign abs_b  = fix32(sign_b, md.srcbE);

    // Multiply: work = {partial product, remaining multiplier bits}, shift right each step.
    assign msum     = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, opnd_q} : 33'd0);
    assign mul_step = {msum, work_q[31:1]};

`ifdef MULDIV_DIVIDE_EN
    logic        div_q, div_d;
    logic        bzero_q, bzero_d;
    logic [32:0] dtop;
    logic        dge;
    logic [31:0] drem;
    logic [63:0] div_step;

    // Divide: work = {remainder, dividend/quotient}; the shifted-out dividend bit joins the trial remainder.
    assign dtop      = work_q[63:31];
    assign dge       = dtop >= {1'b0, opnd_q};
    assign drem      = dtop[31:0] - opnd_q;
    assign div_step  = dge ? {drem, work_q[30:0], 1'b1} : {work_q[62:0], 1'b0};
    assign step      = div_q ? div_step : mul_step;
    assign start_div = md.opE[1];
    assign accept    = md.startE;

    always_comb begin
        {res_hi, res_lo} = fix64(sa_q ^ sb_q, step);
        if (div_q) begin
            res_hi = fix32(sa_q, step[63:32]);
            res_lo = bzero_q ? 32'hFFFF_FFFF : fix32(sa_q ^ sb_q, step[31:0]);
        end
    end

    always_comb begin
        div_d   = div_q;
        bzero_d = bzero_q;
        if (!busy && accept) begin
            div_d   = start_div;
            bzero_d = (md.srcbE == 32'd0);
        end
    end

    always_ff @(posedge clk) begin
        div_q   <= div_d;
        bzero_q <= bzero_d;
    end
`else
    assign step      = mul_step;
    assign start_div = 1'b0;
    assign accept    = md.startE & ~md.opE[1];
    assign {res_hi, res_lo} = fix64(sa_q ^ sb_q, step);
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        work_d  = work_q;
        opnd_d  = opnd_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                    count_d = 6'd32;
                    sa_d    = sign_a;
                    sb_d    = sign_b;
                    opnd_d  = start_div ? abs_b : abs_a;
                    work_d  = {32'd0, start_div ? abs_a : abs_b};
                end
            end
            BUSY: begin
                work_d  = step;
                count_d = count_q - 6'd1;
                if (count_q == 6'd1) begin
                    state_d = IDLE;
                    hi_d    = res_hi;
                    lo_d    = res_lo;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= 6'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    // Datapath registers need no reset: they are reloaded on every accepted operation.
    always_ff @(posedge clk) begin
        work_q <= work_d;
        opnd_q <= opnd_d;
        sa_q   <= sa_d;
        sb_q   <= sb_d;
    end

    assign md.busy    = busy;
    assign md.stallMD = busy & (md.startE | md.hiloreadE);
    assign md.done    = done_q;
    assign md.hi      = hi_q;
    assign md.lo      = lo_q;

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on the rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port startE, input, 1, valid MULT/MULTU/DIV/DIVU in the E stage, already qualified (not flushed).
REQ-004 SHALL have port opE, input, 2, operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-005 SHALL have port srcaE, input, 32, rs operand (multiplicand or dividend).
REQ-006 SHALL have port srcbE, input, 32, rt operand (multiplier or divisor).
REQ-007 SHALL have port hiloreadE, input, 1, MFHI/MFLO in the E stage.
REQ-008 SHALL have port busy, output, 1, iteration in progress.
REQ-009 SHALL have port stallMD, output, 1, stall request to the hazard logic; freezes F, D and E.
REQ-010 SHALL have port done, output, 1, one-cycle pulse when HI/LO are written.
REQ-011 SHALL have port hi, output, 32, HI register.
REQ-012 SHALL have port lo, output, 32, LO register.

Function
REQ-013 SHALL implement the FSM IDLE -> BUSY -> IDLE with a 6-bit iteration counter.
REQ-014 SHALL, in IDLE with startE=1 and a legal op, latch |srcaE|, |srcbE|, the sign flags and the op, load count=32 and enter BUSY on the next edge.
REQ-015 SHALL perform one radix-2 step per BUSY cycle: shift-add for multiply, restoring shift-subtract for divide.
REQ-016 SHALL keep BUSY for exactly 32 cycles; on the edge ending the 32nd cycle it writes hi/lo, pulses done for the following cycle, and returns to IDLE.
REQ-017 SHALL hold busy=1 in BUSY and 0 otherwise.
REQ-018 SHALL use unsigned operands directly for MULTU/DIVU.
REQ-019 SHALL, for MULT/DIV, operate on magnitudes and apply sign correction in the final write cycle with no extra latency.
REQ-020 SHALL, for MULT, negate the 64-bit product when the operand signs differ: {hi,lo}=product.
REQ-021 SHALL, for DIV, take the quotient sign as sa^sb and the remainder sign as sa: lo=quotient, hi=remainder.
REQ-022 SHALL, for divide by zero (srcbE=0), write lo=0xFFFFFFFF and hi=srcaE unchanged in both signed and unsigned forms.
REQ-023 SHALL produce lo=0x80000000, hi=0 for DIV 0x80000000 / 0xFFFFFFFF.
REQ-024 SHALL drive stallMD = busy & (startE | hiloreadE); combinational; 0 in IDLE.
REQ-025 SHALL ignore startE while BUSY (no restart); the stalled instruction is accepted in the first IDLE cycle.
REQ-026 SHALL, when startE arrives in the cycle done is high, accept it (IDLE) with the hi/lo just written remaining stable until the new operation completes.
REQ-027 SHALL hold hi/lo constant except on a completion write.

Reset
REQ-028 SHALL, on reset, set state=IDLE, count=0, hi=0, lo=0, busy=0, done=0, stallMD=0.
REQ-029 SHALL, on reset asserted mid-operation, abort the operation, leave no partial result, and give reset values on the next cycle.
REQ-030 SHALL give reset priority over startE in the same cycle.

Configuration
REQ-031 SHALL compile divide support only when macro MULDIV_DIVIDE_EN is defined.
REQ-032 SHALL, without MULDIV_DIVIDE_EN, treat opE 10/11 as no-ops: no BUSY, no done, hi/lo unchanged, stallMD=0; multiply behaviour unchanged.

Verification
REQ-033 SHALL cover: MULTU 0xFFFFFFFF*0xFFFFFFFF -> busy for 32 cycles, then hi=0xFFFFFFFE, lo=0x00000001, done one cycle.
REQ-034 SHALL cover: MULT 0xFFFFFFFD(-3)*0x00000005 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-035 SHALL cover: DIV 0xFFFFFFF9(-7)/0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 0x0000000A/0 -> lo=0xFFFFFFFF, hi=0x0000000A.
REQ-036 SHALL cover: hiloreadE=1 from BUSY cycle 5 -> stallMD=1 through cycle 32, stallMD=0 in the first IDLE cycle, hi/lo hold the new result.
REQ-037 SHALL cover: second startE during BUSY -> stallMD=1, no restart; the new op starts in the first IDLE cycle and completes 32 cycles later.
REQ-038 SHALL cover: reset at BUSY cycle 10 -> next cycle busy=0, hi=lo=0, no done pulse; MULTU without MULDIV_DIVIDE_EN -> startE with opE=10 gives busy=0.
